// File: rtl/arm_shift_pipe.sv
// Pipelined ARM-style barrel shifter (LSL/LSR/ASR/ROR/RRX) with valid/ready flow control.
// Optional N/Z flag outputs are enabled by defining ARM_SHIFT_FLAGS_EN.
module arm_shift_pipe #(
  parameter int DATA_W = 32,
  parameter int NUM_W  = 8,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        shift_op,
  input  logic [DATA_W-1:0] shift_data,
  input  logic [NUM_W-1:0]  shift_num,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] shift_out,
  output logic              carry_out,
`ifdef ARM_SHIFT_FLAGS_EN
  output logic              flag_n,
  output logic              flag_z,
`endif
  output logic              busy
);

  localparam int LW = $clog2(DATA_W);
  localparam logic [LW-1:0] FULL_MASK   = '1;
  localparam logic [LW-1:0] COARSE_MASK = FULL_MASK << (LW / 2);

  typedef enum logic [1:0] {K_PASS, K_LSL, K_SHR, K_ROR} kind_t;

  // Decode reduces every case to a pass-through or a shift by 1..W-1,
  // with the carry already resolved, so later stages only move bits.
  typedef struct packed {
    logic              valid;
    kind_t             kind;
    logic              fill;
    logic              carry;
    logic [LW-1:0]     amt;
    logic [DATA_W-1:0] data;
  } stage_t;

  function automatic stage_t shift_by(input stage_t s, input logic [LW-1:0] mask);
    stage_t        r;
    logic [LW-1:0] a;
    r = s;
    a = s.amt & mask;
    case (s.kind)
      K_LSL:   r.data = s.data << a;
      K_SHR:   r.data = DATA_W'({{DATA_W{s.fill}}, s.data} >> a);
      K_ROR:   r.data = DATA_W'({s.data, s.data} >> a);
      default: r.data = s.data;
    endcase
    r.amt = s.amt & ~mask;
    return r;
  endfunction

  logic   advance;
  stage_t dec;
  stage_t stage_in  [1:STAGES];
  stage_t stage_reg [1:STAGES];

  assign out_valid = stage_reg[STAGES].valid;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign shift_out = stage_reg[STAGES].data;
  assign carry_out = stage_reg[STAGES].carry;

  always_comb begin
    int unsigned   ne;
    logic [LW-1:0] idx;
    logic          msb;
    dec       = '0;
    dec.valid = in_valid;
    dec.kind  = K_PASS;
    dec.data  = shift_data;
    dec.carry = carry_in;
    ne        = 32'(shift_num);
    idx       = '0;
    msb       = shift_data[DATA_W-1];
    if (ne == 0 && (shift_op[0] || shift_op[2:1] == 2'b00)) begin
      dec.kind = K_PASS;
    end else begin
      case (shift_op[2:1])
        2'b00: begin
          if (ne < DATA_W) begin
            dec.kind  = K_LSL;
            dec.amt   = LW'(ne);
            idx       = LW'(DATA_W - ne);
            dec.carry = shift_data[idx];
          end else begin
            dec.data  = '0;
            dec.carry = (ne == DATA_W) ? shift_data[0] : 1'b0;
          end
        end
        2'b01, 2'b10: begin
          if (ne == 0) ne = DATA_W;
          idx = LW'(ne - 1);
          if (ne < DATA_W) begin
            dec.kind  = K_SHR;
            dec.fill  = shift_op[2] & msb;
            dec.amt   = LW'(ne);
            dec.carry = shift_data[idx];
          end else if (shift_op[2]) begin
            dec.data  = {DATA_W{msb}};
            dec.carry = msb;
          end else begin
            dec.data  = '0;
            dec.carry = (ne == DATA_W) & msb;
          end
        end
        default: begin
          if (ne == 0) begin
            dec.data  = {carry_in, shift_data[DATA_W-1:1]};
            dec.carry = shift_data[0];
          end else begin
            // r == 0 wraps idx to W-1, which is exactly the carry wanted
            dec.amt   = LW'(ne);
            dec.kind  = (dec.amt == '0) ? K_PASS : K_ROR;
            idx       = dec.amt - LW'(1);
            dec.carry = shift_data[idx];
          end
        end
      endcase
    end
  end

  // The last stage always applies whatever amount is left, so any depth ends fully shifted.
  always_comb begin
    stage_in[1] = (STAGES == 1) ? shift_by(dec, FULL_MASK) : dec;
    for (int i = 2; i <= STAGES; i++)
      stage_in[i] = shift_by(stage_reg[i-1], (i == STAGES) ? FULL_MASK : COARSE_MASK);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i <= STAGES; i++) stage_reg[i] <= '0;
    end else if (advance) begin
      for (int i = 1; i <= STAGES; i++) stage_reg[i] <= stage_in[i];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 1; i <= STAGES; i++) busy = busy | stage_reg[i].valid;
  end

`ifdef ARM_SHIFT_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
    end else if (advance) begin
      flag_n <= stage_in[STAGES].data[DATA_W-1];
      flag_z <= (stage_in[STAGES].data == '0);
    end
  end
`endif

endmodule
